// File: rtl/execute_mc_if.sv
// execute_mc_if
//   Handshake bundle between the issue stage / ROB and the execute unit.
//   master : issuer side (drives in_* payload, squash and out_ready)
//   slave  : execute_mc side (drives in_ready and out_* result)
//   Signals: in_valid/in_ready + in_tag, in_op, in_pc, in_imm, in_br_off,
//            in_rs1, in_rs2, in_is_br, in_ld_data; squash;
//            out_valid/out_ready + out_tag, out_rd_data, out_mem_addr,
//            out_mem_data, out_taken, out_next_pc.
//   Opcode encoding falls back to a local definition when param.v has not
//   already provided the `INST_* macros.

`ifndef INST_SIZE_LOG
`define INST_SIZE_LOG 3
`define INST_OP_NOP 3'd0
`define INST_OP_LI  3'd1
`define INST_OP_ADD 3'd2
`define INST_OP_MUL 3'd3
`define INST_OP_LD  3'd4
`define INST_OP_ST  3'd5
`define INST_OP_BR  3'd6
`endif

interface execute_mc_if #(
  parameter int REG_W  = 32,
  parameter int PC_W   = 4,
  parameter int ADDR_W = 2,
  parameter int TAG_W  = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [TAG_W-1:0]          in_tag;
  logic [`INST_SIZE_LOG-1:0] in_op;
  logic [PC_W-1:0]           in_pc;
  logic [REG_W-1:0]          in_imm;
  logic [PC_W-1:0]           in_br_off;
  logic [REG_W-1:0]          in_rs1;
  logic [REG_W-1:0]          in_rs2;
  logic                      in_is_br;
  logic [REG_W-1:0]          in_ld_data;
  logic                      squash;
  logic                      out_valid;
  logic                      out_ready;
  logic [TAG_W-1:0]          out_tag;
  logic [REG_W-1:0]          out_rd_data;
  logic [ADDR_W-1:0]         out_mem_addr;
  logic [REG_W-1:0]          out_mem_data;
  logic                      out_taken;
  logic [PC_W-1:0]           out_next_pc;

  modport master (
    output in_valid, in_tag, in_op, in_pc, in_imm, in_br_off, in_rs1, in_rs2,
           in_is_br, in_ld_data, squash, out_ready,
    input  in_ready, out_valid, out_tag, out_rd_data, out_mem_addr,
           out_mem_data, out_taken, out_next_pc
  );

  modport slave (
    input  in_valid, in_tag, in_op, in_pc, in_imm, in_br_off, in_rs1, in_rs2,
           in_is_br, in_ld_data, squash, out_ready,
    output in_ready, out_valid, out_tag, out_rd_data, out_mem_addr,
           out_mem_data, out_taken, out_next_pc
  );
endinterface

// File: rtl/execute_mc.sv
// execute_mc
//   Multi-cycle execute unit: accepts one op per handshake, computes the
//   ALU / load-forward / branch result and returns it with its tag. MUL is
//   timed by a down-counter (MUL_LAT cycles); every other op takes 1 cycle.
//   Ports:
//     i_clk   clock
//     i_rst   synchronous active-high reset
//     io_exe  execute_mc_if.slave (issue handshake, squash, result handshake)
//   Build option:
//     EXEC_MUL_EARLY_ZERO_EN  MUL with a zero operand completes in 1 cycle
//                             (intentional data-dependent latency).
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ST_IDLE     | empty, ready to accept
//   ST_MUL_BUSY | MUL in flight, r_cnt counting down
//   ST_HOLD     | result presented, waiting for out_ready

module execute_mc #(
  parameter int REG_W   = 32,
  parameter int PC_W    = 4,
  parameter int ADDR_W  = 2,
  parameter int TAG_W   = 3,
  parameter int MUL_LAT = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  execute_mc_if.slave io_exe
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_zero;
  logic              w_mul_fast;
  logic [REG_W-1:0]  w_prod;
  logic [REG_W-1:0]  w_rd_data;
  logic              w_taken;
  logic [PC_W-1:0]   w_next_pc;

  logic [TAG_W-1:0]  r_tag;
  logic [REG_W-1:0]  r_rd_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [REG_W-1:0]  r_mem_data;
  logic              r_taken;
  logic [PC_W-1:0]   r_next_pc;

  assign w_in_ready = !i_rst && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_HOLD) && io_exe.out_ready));
  assign w_accept   = io_exe.in_valid && w_in_ready && !io_exe.squash;
  assign w_is_mul   = (io_exe.in_op == `INST_OP_MUL);
  assign w_prod     = io_exe.in_rs1 * io_exe.in_rs2;

`ifdef EXEC_MUL_EARLY_ZERO_EN
  assign w_mul_zero = (io_exe.in_rs1 == '0) || (io_exe.in_rs2 == '0);
`else
  assign w_mul_zero = 1'b0;
`endif

  // A 1-cycle MUL skips MUL_BUSY entirely and goes straight to HOLD.
  assign w_mul_fast = w_mul_zero || (MUL_LAT == 1);

  always_comb begin
    w_rd_data = '0;
    case (io_exe.in_op)
      `INST_OP_LI:  w_rd_data = io_exe.in_imm;
      `INST_OP_ADD: w_rd_data = io_exe.in_rs1 + io_exe.in_rs2;
      `INST_OP_MUL: w_rd_data = w_prod;
      `INST_OP_LD:  w_rd_data = io_exe.in_ld_data;
      default:      w_rd_data = '0;
    endcase
  end

  assign w_taken   = (io_exe.in_rs2 == '0);
  assign w_next_pc = (io_exe.in_is_br && w_taken) ? io_exe.in_pc + io_exe.in_br_off
                                                  : io_exe.in_pc + PC_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: ;
      ST_MUL_BUSY: begin
        // Leaving on cnt==1 makes out_valid rise exactly MUL_LAT cycles after accept.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLD: if (io_exe.out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_accept) begin
      if (w_is_mul && !w_mul_fast) begin
        w_state_nxt = ST_MUL_BUSY;
        w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
      end else begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
      end
    end
    // Squash overrides both completion and out_ready.
    if (io_exe.squash) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Result is captured at accept so later input changes cannot disturb it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag      <= '0;
      r_rd_data  <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_taken    <= 1'b0;
      r_next_pc  <= '0;
    end else if (w_accept) begin
      r_tag      <= io_exe.in_tag;
      r_rd_data  <= w_rd_data;
      r_mem_addr <= io_exe.in_rs1[ADDR_W-1:0];
      r_mem_data <= io_exe.in_rs2;
      r_taken    <= w_taken;
      r_next_pc  <= w_next_pc;
    end
  end

  assign io_exe.in_ready     = w_in_ready;
  assign io_exe.out_valid    = (r_state == ST_HOLD);
  assign io_exe.out_tag      = r_tag;
  assign io_exe.out_rd_data  = r_rd_data;
  assign io_exe.out_mem_addr = r_mem_addr;
  assign io_exe.out_mem_data = r_mem_data;
  assign io_exe.out_taken    = r_taken;
  assign io_exe.out_next_pc  = r_next_pc;

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: self-checking bench for execute_mc with a behavioural
// reference model (result value and latency computed from the op rules).

`ifndef INST_SIZE_LOG
`define INST_SIZE_LOG 3
`define INST_OP_NOP 3'd0
`define INST_OP_LI  3'd1
`define INST_OP_ADD 3'd2
`define INST_OP_MUL 3'd3
`define INST_OP_LD  3'd4
`define INST_OP_ST  3'd5
`define INST_OP_BR  3'd6
`endif

module tb_execute_mc;
  localparam int REG_W = 32, PC_W = 4, ADDR_W = 2, TAG_W = 3, MUL_LAT = 4;

  typedef struct packed {
    logic [`INST_SIZE_LOG-1:0] op;
    logic [TAG_W-1:0]          tag;
    logic [PC_W-1:0]           pc;
    logic [REG_W-1:0]          imm;
    logic [PC_W-1:0]           off;
    logic [REG_W-1:0]          rs1;
    logic [REG_W-1:0]          rs2;
    logic                      is_br;
    logic [REG_W-1:0]          ld;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  execute_mc_if #(.REG_W(REG_W), .PC_W(PC_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  execute_mc #(.REG_W(REG_W), .PC_W(PC_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
               .MUL_LAT(MUL_LAT)) dut (.i_clk(clk), .i_rst(rst), .io_exe(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [REG_W-1:0] ref_rd(op_t o);
    logic [63:0] p;
    logic [32:0] s;
    p = {32'b0, o.rs1} * {32'b0, o.rs2};
    s = {1'b0, o.rs1} + {1'b0, o.rs2};
    case (o.op)
      `INST_OP_LI:  return o.imm;
      `INST_OP_ADD: return s[31:0];
      `INST_OP_MUL: return p[31:0];
      `INST_OP_LD:  return o.ld;
      default:      return '0;
    endcase
  endfunction

  function automatic logic [PC_W-1:0] ref_npc(op_t o);
    int t;
    if (o.is_br && o.rs2 == 0) t = int'(o.pc) + int'(o.off);
    else                       t = int'(o.pc) + 1;
    t = t % (1 << PC_W);
    return PC_W'(t);
  endfunction

  function automatic int ref_lat(op_t o);
    if (o.op != `INST_OP_MUL) return 1;
`ifdef EXEC_MUL_EARLY_ZERO_EN
    if (o.rs1 == 0 || o.rs2 == 0) return 1;
`endif
    return MUL_LAT;
  endfunction

  function automatic op_t mk(logic [`INST_SIZE_LOG-1:0] op, logic [REG_W-1:0] rs1,
                             logic [REG_W-1:0] rs2, logic [TAG_W-1:0] tag);
    op_t o;
    o.op = op; o.rs1 = rs1; o.rs2 = rs2; o.tag = tag;
    o.pc = PC_W'($urandom); o.imm = $urandom; o.off = PC_W'($urandom);
    o.is_br = 1'b0; o.ld = $urandom;
    return o;
  endfunction

  function automatic op_t rand_op();
    logic [`INST_SIZE_LOG-1:0] ops [7];
    op_t o;
    ops = '{`INST_OP_NOP, `INST_OP_LI, `INST_OP_ADD, `INST_OP_MUL,
            `INST_OP_LD, `INST_OP_ST, `INST_OP_BR};
    o = mk(ops[$urandom_range(0, 6)], $urandom, $urandom, TAG_W'($urandom));
    if ($urandom_range(0, 3) == 0) o.rs1 = '0;
    if ($urandom_range(0, 3) == 0) o.rs2 = '0;
    o.is_br = (o.op == `INST_OP_BR) ? 1'b1 : 1'($urandom);
    return o;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(op_t o);
    bus.in_valid = 1'b1; bus.in_op = o.op; bus.in_tag = o.tag; bus.in_pc = o.pc;
    bus.in_imm = o.imm; bus.in_br_off = o.off; bus.in_rs1 = o.rs1;
    bus.in_rs2 = o.rs2; bus.in_is_br = o.is_br; bus.in_ld_data = o.ld;
  endtask

  task automatic scramble();
    bus.in_valid = 1'b0; bus.in_op = `INST_SIZE_LOG'($urandom);
    bus.in_tag = TAG_W'($urandom); bus.in_pc = PC_W'($urandom);
    bus.in_imm = $urandom; bus.in_br_off = PC_W'($urandom); bus.in_rs1 = $urandom;
    bus.in_rs2 = $urandom; bus.in_is_br = 1'($urandom); bus.in_ld_data = $urandom;
  endtask

  task automatic accept();
    @(posedge clk); #1;
    scramble();
  endtask

  // Called just after the accept edge; returns cycles until out_valid (99 = timeout).
  task automatic wait_valid(output int lat, output int busy);
    lat = 99; busy = 0;
    for (int c = 1; c <= 20 && lat == 99; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) lat = c;
      else if (bus.in_ready === 1'b0) busy++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; bus.squash = 1'b0; bus.out_ready = 1'b0; scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    rst = 1'b0; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.out_rd_data !== '0 || bus.out_tag !== '0 || bus.out_next_pc !== '0 ||
                    bus.out_taken !== 1'b0 || bus.out_mem_data !== '0 || bus.out_mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_outputs got rd=%h tag=%h npc=%h tk=%b md=%h ma=%h exp all 0",
        bus.out_rd_data, bus.out_tag, bus.out_next_pc, bus.out_taken, bus.out_mem_data, bus.out_mem_addr);
    end
  endtask

  task automatic test_li();
    op_t o; int lat, busy;
    o = mk(`INST_OP_LI, 32'h9, 32'h1, 3'd3); o.imm = 32'h5; o.pc = 4'h2;
    @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL li_latency got=%0d exp=1", lat); end
    n_checks++; if (bus.out_rd_data !== 32'h5) begin n_fail++; $display("FAIL li_rd got=%h exp=5", bus.out_rd_data); end
    n_checks++; if (bus.out_tag !== 3'd3) begin n_fail++; $display("FAIL li_tag got=%h exp=3", bus.out_tag); end
    n_checks++; if (bus.out_next_pc !== 4'h3) begin n_fail++; $display("FAIL li_next_pc got=%h exp=3", bus.out_next_pc); end
    consume(); @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL li_after_consume got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_add_wrap();
    op_t o; int lat, busy;
    o = mk(`INST_OP_ADD, 32'hFFFF_FFFF, 32'h1, 3'd5);
    @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got=%0d exp=1", lat); end
    n_checks++; if (bus.out_rd_data !== 32'h0) begin n_fail++; $display("FAIL add_wrap_rd got=%h exp=0", bus.out_rd_data); end
    n_checks++; if (bus.out_mem_data !== 32'h1 || bus.out_mem_addr !== 2'd3) begin
      n_fail++; $display("FAIL add_mem got data=%h addr=%h exp data=1 addr=3", bus.out_mem_data, bus.out_mem_addr);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    op_t q[$]; op_t o; op_t e;
    @(negedge clk);
    bus.out_ready = 1'b1;
    o = mk(`INST_OP_ADD, $urandom, $urandom, 3'd0); drive(o); q.push_back(o);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i < 5) begin
        o = mk((i % 2) ? `INST_OP_LI : `INST_OP_ADD, $urandom, $urandom, TAG_W'(i + 1));
        drive(o); q.push_back(o);
      end else scramble();
      @(negedge clk);
      e = q.pop_front();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      n_checks++; if (bus.out_rd_data !== ref_rd(e) || bus.out_tag !== e.tag) begin
        n_fail++; $display("FAIL b2b_result[%0d] got rd=%h tag=%h exp rd=%h tag=%h", i, bus.out_rd_data, bus.out_tag, ref_rd(e), e.tag);
      end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
    end
    @(posedge clk); #1; bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_mul();
    op_t o; int lat, busy;
    o = mk(`INST_OP_MUL, 32'd3, 32'd7, 3'd6);
    @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
    n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); end
    n_checks++; if (busy !== MUL_LAT - 1) begin n_fail++; $display("FAIL mul_busy got=%0d exp=%0d", busy, MUL_LAT - 1); end
    n_checks++; if (bus.out_rd_data !== 32'd21) begin n_fail++; $display("FAIL mul_rd got=%0d exp=21", bus.out_rd_data); end
    consume();
    o = mk(`INST_OP_MUL, 32'h8000_0003, 32'h0001_0005, 3'd1);
    @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
    n_checks++; if (bus.out_rd_data !== ref_rd(o)) begin n_fail++; $display("FAIL mul_wrap_rd got=%h exp=%h", bus.out_rd_data, ref_rd(o)); end
    consume();
  endtask

  task automatic test_mul_zero();
    op_t o; int lat, busy;
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? mk(`INST_OP_MUL, 32'd0, 32'd9, 3'd2) : mk(`INST_OP_MUL, 32'd9, 32'd0, 3'd4);
      @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
      n_checks++; if (lat !== ref_lat(o)) begin n_fail++; $display("FAIL mul_zero_latency[%0d] got=%0d exp=%0d", k, lat, ref_lat(o)); end
      n_checks++; if (bus.out_rd_data !== 32'd0) begin n_fail++; $display("FAIL mul_zero_rd[%0d] got=%h exp=0", k, bus.out_rd_data); end
      consume();
    end
  endtask

  task automatic test_branch();
    op_t o; int lat, busy;
    logic [REG_W-1:0] rs2v [3];
    logic             br    [3];
    logic             exp_t [3];
    logic [PC_W-1:0]  exp_p [3];
    rs2v = '{32'd0, 32'd2, 32'd0}; br = '{1'b1, 1'b1, 1'b0};
    exp_t = '{1'b1, 1'b0, 1'b1}; exp_p = '{4'h1, 4'hF, 4'hF};
    for (int k = 0; k < 3; k++) begin
      o = mk(`INST_OP_BR, 32'h10, rs2v[k], 3'd7);
      o.pc = 4'hE; o.off = 4'd3; o.is_br = br[k];
      @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
      n_checks++; if (bus.out_taken !== exp_t[k] || bus.out_next_pc !== exp_p[k]) begin
        n_fail++; $display("FAIL branch[%0d] got taken=%b npc=%h exp taken=%b npc=%h",
          k, bus.out_taken, bus.out_next_pc, exp_t[k], exp_p[k]);
      end
      n_checks++; if (bus.out_rd_data !== 32'd0) begin n_fail++; $display("FAIL branch_rd[%0d] got=%h exp=0", k, bus.out_rd_data); end
      consume();
    end
  endtask

  task automatic test_load_store();
    op_t o; int lat, busy;
    o = mk(`INST_OP_LD, 32'hABCD_0006, 32'h1234, 3'd2); o.ld = 32'hCAFE_F00D;
    @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
    n_checks++; if (bus.out_rd_data !== 32'hCAFE_F00D || bus.out_mem_addr !== 2'd2) begin
      n_fail++; $display("FAIL load got rd=%h addr=%h exp rd=cafef00d addr=2", bus.out_rd_data, bus.out_mem_addr);
    end
    consume();
    o = mk(`INST_OP_ST, 32'h5, 32'hDEAD_BEEF, 3'd3);
    @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
    n_checks++; if (bus.out_rd_data !== 32'd0 || bus.out_mem_data !== 32'hDEAD_BEEF || bus.out_mem_addr !== 2'd1) begin
      n_fail++; $display("FAIL store got rd=%h data=%h addr=%h exp rd=0 data=deadbeef addr=1",
        bus.out_rd_data, bus.out_mem_data, bus.out_mem_addr);
    end
    consume();
  endtask

  task automatic test_squash_mul();
    op_t o; int bad;
    o = mk(`INST_OP_MUL, 32'd5, 32'd6, 3'd5);
    @(negedge clk); drive(o); accept();
    @(posedge clk); #1; bus.squash = 1'b1;
    @(posedge clk); #1; bus.squash = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL squash_mul got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    bad = 0;
    repeat (MUL_LAT + 2) begin @(negedge clk); if (bus.out_valid !== 1'b0) bad++; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL squash_mul_dropped got=%0d valid cycles exp=0", bad); end
  endtask

  task automatic test_squash_hold();
    op_t o; int lat, busy, bad;
    o = mk(`INST_OP_LI, 32'd1, 32'd2, 3'd4); o.imm = 32'h1357_9BDF;
    @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1; scramble();
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_rd_data !== 32'h1357_9BDF || bus.out_tag !== 3'd4) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad); end
    drive(mk(`INST_OP_ADD, 32'd1, 32'd1, 3'd1));
    bus.out_ready = 1'b1; bus.squash = 1'b1;
    @(posedge clk); #1;
    bus.squash = 1'b0; bus.out_ready = 1'b0; scramble();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL squash_hold got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (bus.out_valid !== 1'b0) bad++; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL squash_hold_no_accept got=%0d valid cycles exp=0", bad); end
  endtask

  task automatic test_rst_mid_mul();
    op_t o; int bad;
    o = mk(`INST_OP_MUL, 32'h1234, 32'd3, 3'd7);
    @(negedge clk); drive(o); accept();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_rd_data !== '0 || bus.out_tag !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_mul got valid=%b rd=%h tag=%h ready=%b exp 0 0 0 1",
        bus.out_valid, bus.out_rd_data, bus.out_tag, bus.in_ready);
    end
    bad = 0;
    repeat (MUL_LAT + 1) begin @(negedge clk); if (bus.out_valid !== 1'b0) bad++; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_mul_dropped got=%0d valid cycles exp=0", bad); end
  endtask

  task automatic test_random();
    op_t o; int lat, busy, stall;
    for (int i = 0; i < 40; i++) begin
      o = rand_op();
      @(negedge clk); drive(o); accept(); wait_valid(lat, busy);
      n_checks++; if (lat !== ref_lat(o)) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", i, o.op, lat, ref_lat(o)); end
      n_checks++; if (bus.out_rd_data !== ref_rd(o) || bus.out_tag !== o.tag) begin
        n_fail++; $display("FAIL rand_result[%0d] op=%0d got rd=%h tag=%h exp rd=%h tag=%h",
          i, o.op, bus.out_rd_data, bus.out_tag, ref_rd(o), o.tag);
      end
      n_checks++; if (bus.out_taken !== (o.rs2 == 0) || bus.out_next_pc !== ref_npc(o)) begin
        n_fail++; $display("FAIL rand_branch[%0d] got taken=%b npc=%h exp taken=%b npc=%h",
          i, bus.out_taken, bus.out_next_pc, (o.rs2 == 0), ref_npc(o));
      end
      n_checks++; if (bus.out_mem_addr !== o.rs1[ADDR_W-1:0] || bus.out_mem_data !== o.rs2) begin
        n_fail++; $display("FAIL rand_mem[%0d] got addr=%h data=%h exp addr=%h data=%h",
          i, bus.out_mem_addr, bus.out_mem_data, o.rs1[ADDR_W-1:0], o.rs2);
      end
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1; scramble();
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd_data !== ref_rd(o)) begin
          n_fail++; $display("FAIL rand_stall[%0d] got valid=%b rd=%h exp valid=1 rd=%h", i, bus.out_valid, bus.out_rd_data, ref_rd(o));
        end
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_li();
    test_add_wrap();
    test_back_to_back();
    test_mul();
    test_mul_zero();
    test_branch();
    test_load_store();
    test_squash_mul();
    test_squash_hold();
    test_rst_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
